systolic_tile_sequencer: RTL and testbench
==========================================

# systolic_tile_sequencer

Tiling controller for the systolic datapath. On `start` it walks the K×N weight tiles of an M×K · K×N matrix product and drives the sequencing inputs of the array datapath cycle by cycle: buffer enables, base addresses, tile sizes, array operation codes, accumulator control and output drain. It replaces host-side bit-banging of those controls and reports `busy` and `done` to the host register block.

## Interface
- `ARRAY_N`, default 8: array rows; the K-tile size.
- `ARRAY_M`, default 8: array columns; the N-tile size.
- `ADDR_WIDTH`, default 8: width of the buffer RAM addresses.
- `DIM_WIDTH`, default 16: width of the M, K and N inputs.
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin a job. Sampled only in IDLE.
- `M`, `K`, `N`, in, DIM_WIDTH each: matrix dimensions. Latched on an accepted `start`.
- `mode`, in, 1: dataflow mode. Latched on `start` and passed to `mode_out`.
- `busy`, out, 1: a job is in progress.
- `done`, out, 1: one-cycle pulse when a job completes.
- `mode_out`, out, 1: the latched mode.
- `a_buf_on`, `w_buf_on`, out, 1 each: buffer read enables.
- `a_base_addr`, `w_base_addr`, `o_base_addr`, out, ADDR_WIDTH each: tile base addresses.
- `a_num_rows`, out, $clog2(ARRAY_N)+1: valid rows in the current K tile.
- `w_num_cols`, out, $clog2(ARRAY_N)+1: valid columns in the current N tile.
- `operation_signal_in`, out, 3: array opcode. Encodings: 000 NOP, 001 LOAD_W, 010 MAC, 011 FLUSH.
- `o_idx_gen_on`, `o_ag_o_on`, `o_drain`, out, 1 each: output-buffer controls.
- `acc_reset`, `array_contents_reset`, out, 1 each: clear pulses.

## Operation
- States: IDLE, CLEAR, LOAD_W, FEED, DRAIN, DONE.
- Tile counts: KT = ceil(K/ARRAY_N) and NT = ceil(N/ARRAY_M), computed at `start`.
- Tile indices: `kt` and `nt` are registered counters, and `cyc` is the in-state cycle counter.
- IDLE → CLEAR on `start`, provided M, K and N are all nonzero.
- IDLE → DONE directly on `start` if M, K or N is zero. No datapath activity occurs.
- CLEAR (1 cycle): `acc_reset`=1, `array_contents_reset`=1, op NOP, `kt`=0. Next state: LOAD_W.
- LOAD_W (ARRAY_N cycles): `w_buf_on`=1, op LOAD_W. Next state: FEED.
- FEED (M+ARRAY_N+ARRAY_M−2 cycles): `a_buf_on`=1, `o_idx_gen_on`=1, op MAC.
  - If `kt`<KT−1: `kt`++ and go to LOAD_W.
  - Otherwise: go to DRAIN.
- DRAIN (ARRAY_M cycles): `o_ag_o_on`=1, `o_drain`=1, op FLUSH.
  - If `nt`<NT−1: `nt`++ and go to CLEAR.
  - Otherwise: go to DONE.
- DONE (1 cycle): `done`=1. Next state: IDLE.
- Addresses, all truncated to ADDR_WIDTH:
  - `w_base_addr` = (nt·KT+kt)·ARRAY_N
  - `a_base_addr` = kt·M
  - `o_base_addr` = nt·M
- `a_num_rows` = min(ARRAY_N, K−kt·ARRAY_N).
- `w_num_cols` = min(ARRAY_M, N−nt·ARRAY_M). A last partial tile yields the remainder.
- All outputs not listed for a state are 0 in that state. Addresses and tile sizes hold their current tile values throughout the tile.
- `busy` = 1 in every state except IDLE.

## Timing
- All outputs are registered Moore outputs and reflect the current state.
- Reset value: every output is 0 and the state is IDLE. This includes `mode_out` and all addresses.
- `start` accepted at edge t: CLEAR occupies cycle t+1, and `busy` rises in t+1.
- `start` while busy is ignored. Inputs M, K, N and `mode` are don't-care after acceptance.
- Job length from start to done (cycles): NT·(1 + KT·(ARRAY_N + M+ARRAY_N+ARRAY_M−2) + ARRAY_M) + 1. The final +1 is the DONE cycle.
- With `start` and `reset` high together, `reset` wins.
- `reset` mid-job returns to IDLE on the next edge with all outputs 0. No `done` pulse is issued.
- `done` and `busy` are both high for the single DONE cycle. IDLE follows, so a new `start` can be accepted in the cycle after DONE.

## Test plan
- Single tile. Inputs: M=4, K=8, N=8, ARRAY 8×8, `start` at cycle 0.
  - CLEAR at 1, LOAD_W at 2–9, FEED at 10–27, DRAIN at 28–35, `done` at 36.
  - `a_num_rows`=`w_num_cols`=8; all bases 0.
- 2×2 tiles. Inputs: M=4, K=16, N=16.
  - `done` at cycle 123.
  - Second K tile: `w_base_addr`=8, `a_base_addr`=4.
  - Second N tile: `w_base_addr`=16 then 24, `o_base_addr`=4.
  - `acc_reset` pulses exactly twice.
- Partial tiles. Inputs: M=3, K=10, N=5.
  - KT=2 with `a_num_rows`=8 then 2.
  - NT=1 with `w_num_cols`=5.
  - Opcode sequence 000, 001×8, 010×17, 001×8, 010×17, 011×8.
- Zero dimension. Inputs: K=0, `start`.
  - `busy` and `done` high in cycle 1, then IDLE.
  - No buffer enable or opcode other than 000 is ever asserted.
- Start ignored, then reset mid-job. `start` re-pulsed during FEED is ignored and the job length is unchanged. `reset` asserted during LOAD_W produces:
  - all outputs 0 on the next cycle;
  - no `done` pulse;
  - a later `start` that runs normally.
- Mode latch. `mode`=1 at `start`, then 0 during the job → `mode_out` stays 1 until the next accepted `start` or `reset`.

Source files
------------

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer: walks the K x N weight tiles of an M x K * K x N
// product and drives the array datapath sequencing controls cycle by cycle.
// All datapath controls are registered Moore outputs decoded from the next state.
module systolic_tile_sequencer #(
  parameter int ARRAY_N    = 8,
  parameter int ARRAY_M    = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DIM_WIDTH-1:0]    M,
  input  logic [DIM_WIDTH-1:0]    K,
  input  logic [DIM_WIDTH-1:0]    N,
  input  logic                    mode,
  output logic                    busy,
  output logic                    done,
  output logic                    mode_out,
  output logic                    a_buf_on,
  output logic                    w_buf_on,
  output logic [ADDR_WIDTH-1:0]   a_base_addr,
  output logic [ADDR_WIDTH-1:0]   w_base_addr,
  output logic [ADDR_WIDTH-1:0]   o_base_addr,
  output logic [$clog2(ARRAY_N):0] a_num_rows,
  output logic [$clog2(ARRAY_N):0] w_num_cols,
  output logic [2:0]              operation_signal_in,
  output logic                    o_idx_gen_on,
  output logic                    o_ag_o_on,
  output logic                    o_drain,
  output logic                    acc_reset,
  output logic                    array_contents_reset
);

  localparam int NW = $clog2(ARRAY_N) + 1;
  localparam int XW = DIM_WIDTH + 1;  // headroom for ceil() and remainder math
  localparam int CW = DIM_WIDTH + 2;  // FEED length can exceed 2^DIM_WIDTH

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_W, S_FEED, S_DRAIN, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_LOAD_W = 3'b001,
    OP_MAC    = 3'b010,
    OP_FLUSH  = 3'b011
  } op_e;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  a_buf_on;
    logic                  w_buf_on;
    logic [ADDR_WIDTH-1:0] a_base;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] o_base;
    logic [NW-1:0]         rows;
    logic [NW-1:0]         cols;
    op_e                   op;
    logic                  idx_gen;
    logic                  ag_o;
    logic                  drain;
    logic                  acc_reset;
    logic                  arr_reset;
  } ctl_t;

  state_e               state, state_n;
  logic [CW-1:0]        cyc, cyc_n, feed_last;
  logic [DIM_WIDTH-1:0] kt, kt_n, nt, nt_n;
  logic [DIM_WIDTH-1:0] m_r, k_r, n_r, kt_tot, nt_tot;
  logic [DIM_WIDTH-1:0] kt_tot_in, nt_tot_in, k_eff, n_eff;
  logic [XW-1:0]        rem_k, rem_n;
  logic                 take, zero_dim, kt_more, nt_more;
  ctl_t                 ctl_d, ctl_q;

  assign take      = (state == S_IDLE) && start;
  assign zero_dim  = (M == '0) || (K == '0) || (N == '0);
  assign kt_tot_in = DIM_WIDTH'((XW'(K) + XW'(ARRAY_N - 1)) / XW'(ARRAY_N));
  assign nt_tot_in = DIM_WIDTH'((XW'(N) + XW'(ARRAY_M - 1)) / XW'(ARRAY_M));
  assign feed_last = CW'(m_r) + CW'(ARRAY_N + ARRAY_M - 3);
  assign kt_more   = (XW'(kt) + XW'(1)) < XW'(kt_tot);
  assign nt_more   = (XW'(nt) + XW'(1)) < XW'(nt_tot);

  // Next-state, in-state cycle counter and tile index sequencing.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n = state;
    cyc_n   = cyc + CW'(1);
    kt_n    = kt;
    nt_n    = nt;
    unique case (state)
      S_IDLE: begin
        cyc_n = '0;
        if (start) begin
          kt_n    = '0;
          nt_n    = '0;
          state_n = zero_dim ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        cyc_n   = '0;
        kt_n    = '0;
        state_n = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (cyc == CW'(ARRAY_N - 1)) begin
          cyc_n   = '0;
          state_n = S_FEED;
        end
      end
      S_FEED: begin
        if (cyc == feed_last) begin
          cyc_n = '0;
          if (kt_more) begin
            kt_n    = kt + DIM_WIDTH'(1);
            state_n = S_LOAD_W;
          end else begin
            state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (cyc == CW'(ARRAY_M - 1)) begin
          cyc_n = '0;
          if (nt_more) begin
            nt_n    = nt + DIM_WIDTH'(1);
            kt_n    = '0;
            state_n = S_CLEAR;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        cyc_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        cyc_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // On an accepted start the dimension registers still hold the previous job,
  // so tile sizes for the first CLEAR come straight from the inputs. The bases
  // need no bypass: the first tile has kt = nt = 0, which zeroes them anyway.
  assign k_eff = take ? K : k_r;
  assign n_eff = take ? N : n_r;
  assign rem_k = XW'(k_eff) - XW'(kt_n) * XW'(ARRAY_N);
  assign rem_n = XW'(n_eff) - XW'(nt_n) * XW'(ARRAY_M);

  // Output decode for the state being entered, registered below.
  always_comb begin
    ctl_d      = '0;
    ctl_d.op   = OP_NOP;
    ctl_d.busy = (state_n != S_IDLE);
    ctl_d.done = (state_n == S_DONE);
    if (state_n inside {S_CLEAR, S_LOAD_W, S_FEED, S_DRAIN}) begin
      ctl_d.w_base = (ADDR_WIDTH'(nt_n) * ADDR_WIDTH'(kt_tot) + ADDR_WIDTH'(kt_n))
                     * ADDR_WIDTH'(ARRAY_N);
      ctl_d.a_base = ADDR_WIDTH'(kt_n) * ADDR_WIDTH'(m_r);
      ctl_d.o_base = ADDR_WIDTH'(nt_n) * ADDR_WIDTH'(m_r);
      ctl_d.rows   = (rem_k >= XW'(ARRAY_N)) ? NW'(ARRAY_N) : NW'(rem_k);
      ctl_d.cols   = (rem_n >= XW'(ARRAY_M)) ? NW'(ARRAY_M) : NW'(rem_n);
    end
    unique case (state_n)
      S_CLEAR: begin
        ctl_d.acc_reset = 1'b1;
        ctl_d.arr_reset = 1'b1;
      end
      S_LOAD_W: begin
        ctl_d.w_buf_on = 1'b1;
        ctl_d.op       = OP_LOAD_W;
      end
      S_FEED: begin
        ctl_d.a_buf_on = 1'b1;
        ctl_d.idx_gen  = 1'b1;
        ctl_d.op       = OP_MAC;
      end
      S_DRAIN: begin
        ctl_d.ag_o  = 1'b1;
        ctl_d.drain = 1'b1;
        ctl_d.op    = OP_FLUSH;
      end
      default: ;
    endcase
  end

  // State, counters, latched job parameters and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (reset) begin
      state    <= S_IDLE;
      cyc      <= '0;
      kt       <= '0;
      nt       <= '0;
      m_r      <= '0;
      k_r      <= '0;
      n_r      <= '0;
      kt_tot   <= '0;
      nt_tot   <= '0;
      mode_out <= 1'b0;
      ctl_q    <= '0;
    end else begin
      state <= state_n;
      cyc   <= cyc_n;
      kt    <= kt_n;
      nt    <= nt_n;
      ctl_q <= ctl_d;
      if (take) begin
        m_r      <= M;
        k_r      <= K;
        n_r      <= N;
        kt_tot   <= kt_tot_in;
        nt_tot   <= nt_tot_in;
        mode_out <= mode;
      end
    end
  end

  assign busy                 = ctl_q.busy;
  assign done                 = ctl_q.done;
  assign a_buf_on             = ctl_q.a_buf_on;
  assign w_buf_on             = ctl_q.w_buf_on;
  assign a_base_addr          = ctl_q.a_base;
  assign w_base_addr          = ctl_q.w_base;
  assign o_base_addr          = ctl_q.o_base;
  assign a_num_rows           = ctl_q.rows;
  assign w_num_cols           = ctl_q.cols;
  assign operation_signal_in  = ctl_q.op;
  assign o_idx_gen_on         = ctl_q.idx_gen;
  assign o_ag_o_on            = ctl_q.ag_o;
  assign o_drain              = ctl_q.drain;
  assign acc_reset            = ctl_q.acc_reset;
  assign array_contents_reset = ctl_q.arr_reset;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: the driver pushes the full per-cycle
// expected output trace of each job into a queue; a negedge monitor compares.
module tb_systolic_tile_sequencer;

  localparam int AN = 8;
  localparam int AM = 8;

  typedef struct packed {
    logic       busy, done, mode_out, a_buf_on, w_buf_on;
    logic [7:0] a_base, w_base, o_base;
    logic [3:0] rows, cols;
    logic [2:0] op;
    logic       idx, ago, drain, acc_rst, arr_rst;
  } vec_t;

  logic        clk, reset, start, mode;
  logic [15:0] M, K, N;
  logic        busy, done, mode_out, a_buf_on, w_buf_on;
  logic [7:0]  a_base_addr, w_base_addr, o_base_addr;
  logic [3:0]  a_num_rows, w_num_cols;
  logic [2:0]  operation_signal_in;
  logic        o_idx_gen_on, o_ag_o_on, o_drain, acc_reset, array_contents_reset;

  vec_t exp_q[$];
  logic exp_mode;
  int   n_pass = 0;
  int   n_total = 0;

  systolic_tile_sequencer #(
    .ARRAY_N(AN), .ARRAY_M(AM), .ADDR_WIDTH(8), .DIM_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .M(M), .K(K), .N(N), .mode(mode),
    .busy(busy), .done(done), .mode_out(mode_out),
    .a_buf_on(a_buf_on), .w_buf_on(w_buf_on),
    .a_base_addr(a_base_addr), .w_base_addr(w_base_addr), .o_base_addr(o_base_addr),
    .a_num_rows(a_num_rows), .w_num_cols(w_num_cols),
    .operation_signal_in(operation_signal_in),
    .o_idx_gen_on(o_idx_gen_on), .o_ag_o_on(o_ag_o_on), .o_drain(o_drain),
    .acc_reset(acc_reset), .array_contents_reset(array_contents_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    else n_pass++;
  endtask

  // Outputs for one cycle of tile (nt, kt): bases and sizes from the tiling rules.
  function automatic vec_t tile_vec(input int m, k, n, kt_tot, nt, kt, input bit md);
    vec_t v = '0;
    int   rk, rn;
    rk = k - kt * AN;
    rn = n - nt * AM;
    v.busy     = 1'b1;
    v.mode_out = md;
    v.w_base   = 8'((nt * kt_tot + kt) * AN);
    v.a_base   = 8'(kt * m);
    v.o_base   = 8'(nt * m);
    v.rows     = 4'((rk < AN) ? rk : AN);
    v.cols     = 4'((rn < AM) ? rn : AM);
    return v;
  endfunction

  // Expected cycle-by-cycle trace of a job, from the cycle after acceptance to DONE.
  task automatic push_job(input int m, k, n, input bit md);
    vec_t v;
    int   kt_tot, nt_tot;
    if (m == 0 || k == 0 || n == 0) begin
      v = '0; v.busy = 1'b1; v.done = 1'b1; v.mode_out = md;
      exp_q.push_back(v);
      return;
    end
    kt_tot = (k + AN - 1) / AN;
    nt_tot = (n + AM - 1) / AM;
    for (int nt = 0; nt < nt_tot; nt++) begin
      v = tile_vec(m, k, n, kt_tot, nt, 0, md);
      v.acc_rst = 1'b1; v.arr_rst = 1'b1;
      exp_q.push_back(v);
      for (int kt = 0; kt < kt_tot; kt++) begin
        v = tile_vec(m, k, n, kt_tot, nt, kt, md);
        v.w_buf_on = 1'b1; v.op = 3'b001;
        repeat (AN) exp_q.push_back(v);
        v = tile_vec(m, k, n, kt_tot, nt, kt, md);
        v.a_buf_on = 1'b1; v.idx = 1'b1; v.op = 3'b010;
        repeat (m + AN + AM - 2) exp_q.push_back(v);
      end
      v = tile_vec(m, k, n, kt_tot, nt, kt_tot - 1, md);
      v.ago = 1'b1; v.drain = 1'b1; v.op = 3'b011;
      repeat (AM) exp_q.push_back(v);
    end
    v = '0; v.busy = 1'b1; v.done = 1'b1; v.mode_out = md;
    exp_q.push_back(v);
  endtask

  // Monitor: trace entry when a job is expected, otherwise the idle pattern.
  initial begin
    vec_t act, e;
    forever begin
      @(negedge clk);
      act = {busy, done, mode_out, a_buf_on, w_buf_on, a_base_addr, w_base_addr,
             o_base_addr, a_num_rows, w_num_cols, operation_signal_in,
             o_idx_gen_on, o_ag_o_on, o_drain, acc_reset, array_contents_reset};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("trace", 64'(act), 64'(e));
      end else begin
        e = '0; e.mode_out = exp_mode;
        check("idle", 64'(act), 64'(e));
      end
    end
  end

  task automatic run_job(input int m, k, n, input bit md, input bit poke);
    int len, cnt, kt_tot, nt_tot;
    M = 16'(m); K = 16'(k); N = 16'(n); mode = md; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~md;
    M = 16'($urandom); K = 16'($urandom); N = 16'($urandom);
    push_job(m, k, n, md);
    exp_mode = md;
    kt_tot = (k + AN - 1) / AN;
    nt_tot = (n + AM - 1) / AM;
    if (m == 0 || k == 0 || n == 0) len = 1;
    else len = nt_tot * (1 + kt_tot * (AN + m + AN + AM - 2) + AM) + 1;
    cnt = 1;
    while (done !== 1'b1 && cnt < len + 50) begin
      if (poke && cnt == len / 2) begin
        start = 1'b1; mode = $urandom_range(0, 1);
        M = 16'($urandom_range(1, 30)); K = 16'($urandom_range(1, 30));
      end
      @(posedge clk); #1;
      start = 1'b0;
      cnt++;
    end
    check("job_len", 64'(cnt), 64'(len));
    if (done !== 1'b1) exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int m, k, n;
    reset = 1'b1; start = 1'b0; mode = 1'b0; M = '0; K = '0; N = '0;
    exp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_job(4, 8, 8, 1'b0, 1'b0);    // single tile, done at cycle 36
    run_job(4, 16, 16, 1'b0, 1'b0);  // 2x2 tiles, done at cycle 123
    run_job(3, 10, 5, 1'b1, 1'b0);   // partial tiles
    run_job(5, 0, 7, 1'b0, 1'b0);    // zero dimension
    run_job(4, 8, 8, 1'b1, 1'b1);    // mode latch plus ignored re-start in FEED
    repeat (3) @(posedge clk);
    #1;

    // Reset during LOAD_W of a 2x2 job: IDLE with all outputs 0, no done.
    M = 16'd4; K = 16'd16; N = 16'd16; mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_job(4, 16, 16, 1'b1);
    exp_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_mode = 1'b0;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Start and reset together: reset wins.
    M = 16'd4; K = 16'd8; N = 16'd8; mode = 1'b1; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_job(4, 8, 8, 1'b0, 1'b0);    // runs normally after the reset

    for (int i = 0; i < 20; i++) begin
      m = $urandom_range(1, 20);
      k = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
      run_job(m, k, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
